// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared types for the memory port arbiter
package mem_bus_arbiter_pkg;

    typedef enum logic {
        SRC_INSTR = 1'b0,
        SRC_DATA  = 1'b1
    } mem_src_e;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mem_arb_id_fifo.sv
// rtl/mem_arb_id_fifo.sv - 1-bit ID FIFO tracking the issuer of each outstanding transaction
module mem_arb_id_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   push_id,
    input  logic                   pop,
    output logic                   head_id,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A simultaneous pop frees the slot a push needs, so push is accepted when full only with a pop.
    assign do_push = push & (~full | do_pop);
    assign head_id = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_id;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - fetch/LSU arbiter for the shared core memory port
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int MAX_OUTST    = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       instr_req,
    input  logic [31:0]                instr_addr,
    output logic                       instr_gnt,
    output logic [31:0]                instr_rdata,
    output logic                       instr_valid,
    output logic                       instr_error,
    input  logic                       data_req,
    input  logic                       data_wr,
    input  logic [31:0]                data_addr,
    input  logic [31:0]                data_wdata,
    input  logic [3:0]                 data_be,
    output logic                       data_gnt,
    output logic [31:0]                data_rdata,
    output logic                       data_valid,
    output logic                       data_error,
    output logic                       bus_req,
    output logic                       bus_wr,
    output logic [31:0]                bus_addr,
    output logic [31:0]                bus_wdata,
    output logic [3:0]                 bus_be,
    input  logic                       bus_gnt,
    input  logic [31:0]                bus_rdata,
    input  logic                       bus_rvalid,
    input  logic                       bus_err,
    output logic [$clog2(MAX_OUTST):0] outst_cnt,
    output logic                       proto_err
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    arb_state_e      state_q, state_d;
    mem_src_e        lock_src_q, lock_src_d;
    mem_src_e        winner;
    logic            winner_req;
    logic            bus_fire;
    logic [SW-1:0]   starve_q;
    logic            fifo_full;
    logic            fifo_empty;
    logic            head_id;
    logic            rsp_hit;

    always_comb begin
        winner = SRC_INSTR;
        if (state_q == ARB_LOCKED) begin
            winner = lock_src_q;
        end else if (data_req && (starve_q < SW'(STARVE_LIMIT))) begin
            winner = SRC_DATA;
        end else if (instr_req) begin
            winner = SRC_INSTR;
        end else if (data_req) begin
            winner = SRC_DATA;
        end
    end

    assign winner_req = (winner == SRC_DATA) ? data_req : instr_req;
    assign bus_req    = winner_req & ~fifo_full;
    assign bus_fire   = bus_req & bus_gnt;
    assign instr_gnt  = bus_fire & (winner == SRC_INSTR);
    assign data_gnt   = bus_fire & (winner == SRC_DATA);

    assign bus_wr    = (winner == SRC_DATA) ? data_wr    : 1'b0;
    assign bus_addr  = (winner == SRC_DATA) ? data_addr  : instr_addr;
    assign bus_wdata = (winner == SRC_DATA) ? data_wdata : 32'h0;
    assign bus_be    = (winner == SRC_DATA) ? data_be    : 4'hF;

    // Once presented, the request is held on the bus until granted so the address stays stable.
    always_comb begin
        state_d    = state_q;
        lock_src_d = lock_src_q;
        case (state_q)
            ARB_IDLE: begin
                if (bus_req && !bus_gnt) begin
                    state_d    = ARB_LOCKED;
                    lock_src_d = winner;
                end
            end
            ARB_LOCKED: begin
                if (bus_fire || !winner_req) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            lock_src_q <= SRC_INSTR;
        end else begin
            state_q    <= state_d;
            lock_src_q <= lock_src_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= '0;
        end else if (instr_req && !instr_gnt) begin
            if (starve_q != SW'(STARVE_LIMIT)) begin
                starve_q <= starve_q + 1'b1;
            end
        end else begin
            starve_q <= '0;
        end
    end

    mem_arb_id_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_id_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (bus_fire),
        .push_id (winner == SRC_DATA),
        .pop     (bus_rvalid),
        .head_id (head_id),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (outst_cnt)
    );

    assign rsp_hit     = bus_rvalid & ~fifo_empty;
    assign instr_valid = rsp_hit & ~head_id;
    assign data_valid  = rsp_hit & head_id;
    assign instr_rdata = bus_rdata;
    assign data_rdata  = bus_rdata;
    assign instr_error = bus_err & instr_valid;
    assign data_error  = bus_err & data_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            proto_err <= 1'b0;
        end else if (bus_rvalid && fifo_empty) begin
            proto_err <= 1'b1;
        end
    end

endmodule
